// File: rtl/adr_seq.sv
// adr_seq: clocked sequencer for a dual-rail adder (operand latch, spacer/evaluate phases, result hold).
// Optional EVAL watchdog: compile with `define ADR_SEQ_WATCHDOG_EN to enable it; ERR stays 0 otherwise.
`timescale 1ns/1ps
module adr_seq #(
  parameter int WIDTH      = 4,
  parameter int SPACER_CYC = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic             C,
  input  logic             RN,
  input  logic             IN_REQ,
  output logic             IN_ACK,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CI_IN,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic             OP_CI,
  output logic             SP,
  output logic             GO,
  input  logic             DONE,
  input  logic [WIDTH-1:0] SUM_IN,
  input  logic             CO_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {S_IDLE, S_SPACER, S_EVAL, S_RETURN} state_e;

`ifdef ADR_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // Counter values seen on the last required cycle of a phase (counter is 0 on the first).
  localparam logic [7:0] SPC_LAST = 8'(SPACER_CYC - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic             op_ci_q, op_ci_d, co_q, co_d;
  logic             en_q, en_d, out_valid_q, out_valid_d, err_q, err_d;
  logic             slot_free, ack;

  // The result slot is free if empty or being consumed at this very edge.
  assign slot_free = !out_valid_q || OUT_READY;
  assign ack       = RN && (state_q == S_IDLE) && IN_REQ && slot_free;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_ci_d     = op_ci_q;
    sum_d       = sum_q;
    co_d        = co_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !OUT_READY;

    unique case (state_q)
      S_IDLE: begin
        if (ack) begin
          op_a_d  = A_IN;
          op_b_d  = B_IN;
          op_ci_d = CI_IN;
          state_d = S_SPACER;
        end
      end
      S_SPACER: begin
        if (!DONE && (cnt_q >= SPC_LAST)) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (DONE) begin
          sum_d       = SUM_IN;
          co_d        = CO_IN;
          out_valid_d = 1'b1;
          state_d     = S_RETURN;
        end else if (WD_EN && (cnt_q >= TO_LAST)) begin
          sum_d       = '0;
          co_d        = 1'b0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_RETURN;
        end
      end
      S_RETURN: begin
        if (!DONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    en_d  = (state_d == S_EVAL);
    cnt_d = (state_d != state_q) ? 8'd0 :
            (cnt_q == 8'hFF)     ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge C) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!RN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_ci_q     <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_ci_q     <= op_ci_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign IN_ACK    = ack;
  assign OP_A      = op_a_q;
  assign OP_B      = op_b_q;
  assign OP_CI     = op_ci_q;
  assign SP        = en_q;
  assign GO        = en_q;
  assign OUT_VALID = out_valid_q;
  assign SUM       = sum_q;
  assign CO        = co_q;
  assign BUSY      = (state_q != S_IDLE);
  assign ERR       = err_q;

endmodule
